// File: rtl/lu_bitserial_seq.sv
// rtl/lu_bitserial_seq.sv - bit-serial sequencer feeding and collecting an external 1-bit logic cell
module lu_bitserial_seq #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   output logic         ready,
   output logic         busy,
   output logic         cell_a,
   output logic         cell_b,
   output logic [1:0]   cell_s,
   input  logic         cell_y,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         done
);

   // One extra counter bit so the terminal count N-1 never aliases a wrap (N=1, N=2^k).
   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  sa_q;
   logic [N-1:0]  sb_q;
   logic [1:0]    opr_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  sr_q;
   logic [N-1:0]  sr_d;
   logic [N-1:0]  result_q;
   logic          zero_q;
   logic          done_q;

   // Collection register after this cycle's cell bit enters at the MSB (LSB-first arrival).
   always_comb begin
      sr_d        = sr_q >> 1;
      sr_d[N-1]   = cell_y;
   end

   // Control FSM: capture on accept, shift one bit pair per cycle, publish result on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         opr_q    <= 2'b00;
         cnt_q    <= '0;
         sr_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  opr_q   <= op;
                  cnt_q   <= '0;
                  sr_q    <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sr_q  <= sr_d;
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  result_q <= sr_d;
                  zero_q   <= (sr_d == '0);
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Cell inputs come only from registers and are parked at zero outside RUN.
   assign cell_a = (state_q == S_RUN) ? sa_q[0] : 1'b0;
   assign cell_b = (state_q == S_RUN) ? sb_q[0] : 1'b0;
   assign cell_s = (state_q == S_RUN) ? opr_q   : 2'b00;

   assign ready  = (state_q == S_IDLE);
   assign busy   = (state_q != S_IDLE);
   assign result = result_q;
   assign zero   = zero_q;
   assign done   = done_q;

endmodule

// File: tb/tb_lu_bitserial_seq.sv
// tb/tb_lu_bitserial_seq.sv - self-checking bench for lu_bitserial_seq
module tb_lu_bitserial_seq;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [1:0]   op;
   logic         ready;
   logic         busy;
   logic         cell_a;
   logic         cell_b;
   logic [1:0]   cell_s;
   logic         cell_y;
   logic [N-1:0] result;
   logic         zero;
   logic         done;

   int checks   = 0;
   int failures = 0;
   int n_done   = 0;

   typedef struct packed {
      logic [N-1:0] res;
      logic         z;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      logic [N-1:0] va;
      logic [N-1:0] vb;
      logic [1:0]   vop;
      logic [N-1:0] eres;
      logic         ez;
      string        nm;
   } vec_t;

   lu_bitserial_seq #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .op     (op),
      .ready  (ready),
      .busy   (busy),
      .cell_a (cell_a),
      .cell_b (cell_b),
      .cell_s (cell_s),
      .cell_y (cell_y),
      .result (result),
      .zero   (zero),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational model of the 1-bit cell.
   always_comb begin
      cell_y = 1'b0;
      case (cell_s)
         2'b00: cell_y = cell_a & cell_b;
         2'b01: cell_y = cell_a | cell_b;
         2'b10: cell_y = cell_a ^ cell_b;
         2'b11: cell_y = ~cell_a;
         default: cell_y = 1'b0;
      endcase
   end

   function automatic logic [N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                          input logic [1:0] mop);
      case (mop)
         2'b00:   return ma & mb;
         2'b01:   return ma | mb;
         2'b10:   return ma ^ mb;
         default: return ~ma;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Predict an accept at the coming edge and push its expected result.
   always @(negedge clk) begin
      if (rst_n && ready && start) begin
         exp_t e;
         e.res = model(a, b, op);
         e.z   = (model(a, b, op) == '0);
         sbq.push_back(e);
      end
   end

   // Pop and compare whenever the DUT reports a completion.
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_result", 32'(result), 32'(e.res));
            chk("sb_zero", 32'(zero), 32'(e.z));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   // Issue one op with a one-cycle start pulse and check latency and constant expectations.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [1:0] top,
                         input logic [N-1:0] er, input logic ez, input string nm);
      int n_low;
      int done_at;
      wait_ready();
      a = ta; b = tb_v; op = top; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_low   = 0;
      done_at = -1;
      while (!ready && n_low < 50) begin
         n_low++;
         @(posedge clk); #1;
         if (done) begin
            done_at = n_low;
            chk({nm, "_result"}, 32'(result), 32'(er));
            chk({nm, "_zero"}, 32'(zero), 32'(ez));
         end
      end
      chk({nm, "_done_lat"}, 32'(done_at), 32'(N));
      chk({nm, "_ready_low"}, 32'(n_low), 32'(N + 1));
   endtask

   initial begin
      vec_t vecs[$];
      int   d0;
      int   t1;
      int   t2;
      int   n;
      logic [N-1:0] ca;
      logic [N-1:0] cb;
      logic [1:0]   cop;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 2'b00;

      vecs.push_back('{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, "and"});
      vecs.push_back('{8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0, "or"});
      vecs.push_back('{8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0, "xor"});
      vecs.push_back('{8'hF0, 8'h3C, 2'b11, 8'h0F, 1'b0, "not"});
      vecs.push_back('{8'h55, 8'hAA, 2'b00, 8'h00, 1'b1, "zero_and"});
      vecs.push_back('{8'h01, 8'h00, 2'b01, 8'h01, 1'b0, "nz_or"});
      vecs.push_back('{8'hFF, 8'h00, 2'b11, 8'h00, 1'b1, "not_ff"});
      vecs.push_back('{8'h00, 8'hFF, 2'b10, 8'hFF, 1'b0, "xor_ff"});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_cell", 32'({cell_a, cell_b, cell_s}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven ops
      foreach (vecs[i])
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].eres, vecs[i].ez, vecs[i].nm);

      // Result holds between completions
      repeat (4) @(posedge clk);
      #1;
      chk("hold_result", 32'(result), 32'hFF);
      chk("hold_zero", 32'(zero), 32'd0);

      // Start while busy is ignored
      d0 = n_done;
      a = 8'hFF; b = 8'hFF; op = 2'b00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_ready();
      repeat (3) @(posedge clk);
      #1;
      chk("busy_start_ignored_ready", 32'(ready), 32'd1);
      chk("busy_one_done", 32'(n_done - d0), 32'd1);
      chk("busy_result", 32'(result), 32'hFF);

      // Held start: back-to-back ops, done pulses N+2 cycles apart
      a = 8'h3C; b = 8'h0F; op = 2'b01; start = 1'b1;
      t1 = -1; t2 = -1; n = 0;
      while (t2 < 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (done) begin
            if (t1 < 0) t1 = n;
            else t2 = n;
         end
      end
      start = 1'b0;
      chk("held_gap", 32'(t2 - t1), 32'(N + 2));
      chk("held_result", 32'(result), 32'h3F);
      wait_ready();

      // Reset mid-operation
      a = 8'hF0; b = 8'h3C; op = 2'b01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_zero", 32'(zero), 32'd0);
      chk("mid_rst_cell", 32'({cell_a, cell_b, cell_s}), 32'd0);
      sbq.delete();
      d0 = n_done;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("mid_rst_no_done", 32'(n_done - d0), 32'd0);
      run_op(8'h0F, 8'h33, 2'b00, 8'h03, 1'b0, "after_rst");

      // Input stability and cell bit sequence
      for (int k = 0; k < 3; k++) begin
         ca = 8'($urandom); cb = 8'($urandom); cop = 2'($urandom);
         wait_ready();
         a = ca; b = cb; op = cop; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         for (int i = 0; i < N; i++) begin
            chk("seq_cell_a", 32'(cell_a), 32'(ca[i]));
            chk("seq_cell_b", 32'(cell_b), 32'(cb[i]));
            chk("seq_cell_s", 32'(cell_s), 32'(cop));
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            @(posedge clk); #1;
         end
         chk("stab_result", 32'(result), 32'(model(ca, cb, cop)));
         wait_ready();
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
